// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync decoder state type.
// Also used by the VGA timing generator, so the constant names must stay stable.
package vga_timing_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_FRONT      = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BACK       = 48;
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;

    localparam int V_VISIBLE    = 480;
    localparam int V_FRONT      = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BACK       = 33;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

    typedef enum logic [1:0] {
        SEARCH,
        H_LOCK,
        V_ALIGN,
        LOCKED
    } sync_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync line and flags the cycle on which it turns active.
module sync_edge_detect #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic pulse
);

    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= ~POL;
        else     sync_q <= sync_in;
    end

    assign pulse = (sync_in == POL) && (sync_q != POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds haddr/vaddr from raw hsync/vsync, one cycle behind the generator,
// and tracks lock against the expected sync positions.
module vga_sync_decoder #(
    parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK    = vga_timing_pkg::H_BACK,
    parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK    = vga_timing_pkg::V_BACK,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] haddr,
    output logic [9:0] vaddr,
    output logic       active,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] err_count
);

    import vga_timing_pkg::*;

    localparam logic [9:0] HV     = 10'(H_VISIBLE);
    localparam logic [9:0] VV     = 10'(V_VISIBLE);
    localparam logic [9:0] HT_M1  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] VT_M1  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HSS    = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] VSS    = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] HSS_M1 = HSS - 10'd1;
    localparam logic [9:0] VSS_M1 = VSS - 10'd1;

    logic        h_edge, v_edge;
    logic        h_exp, v_exp;
    logic        err;
    logic [9:0]  h_nxt, v_nxt;
    logic        lock_nxt, act_nxt, fs_nxt;
    sync_state_e state, state_nxt;

    sync_edge_detect #(.POL(HSYNC_POL)) u_hsync (
        .clk    (clk),
        .rst    (rst),
        .sync_in(hsync_in),
        .pulse  (h_edge)
    );

    sync_edge_detect #(.POL(VSYNC_POL)) u_vsync (
        .clk    (clk),
        .rst    (rst),
        .sync_in(vsync_in),
        .pulse  (v_edge)
    );

    // Edges land one cycle before the counters reach the generator's sync start.
    assign h_exp = (haddr == HSS_M1);
    assign v_exp = (haddr == HT_M1) && (vaddr == VSS_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            haddr       <= '0;
            vaddr       <= '0;
            locked      <= 1'b0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            haddr       <= h_nxt;
            vaddr       <= v_nxt;
            locked      <= lock_nxt;
            active      <= act_nxt;
            frame_start <= fs_nxt;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        case (state)
            SEARCH: begin
                if (h_edge) state_nxt = H_LOCK;
            end
            H_LOCK: begin
                if (h_edge != h_exp) begin
                    state_nxt = SEARCH;
                    err       = 1'b1;
                end else if (v_edge) begin
                    state_nxt = V_ALIGN;
                end
            end
            V_ALIGN: begin
                if (h_edge != h_exp) begin
                    state_nxt = SEARCH;
                    err       = 1'b1;
                end else if (v_edge) begin
                    if (v_exp) state_nxt = LOCKED;
                    else       err       = 1'b1;
                end
            end
            LOCKED: begin
                if ((h_edge != h_exp) || (v_edge != v_exp)) begin
                    state_nxt = SEARCH;
                    err       = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Free-running counters; a sync edge forces the value the generator is about to show.
    always_comb begin
        h_nxt = (haddr == HT_M1) ? 10'd0 : haddr + 10'd1;
        v_nxt = vaddr;
        if (haddr == HT_M1) v_nxt = (vaddr == VT_M1) ? 10'd0 : vaddr + 10'd1;
        if (h_edge) h_nxt = HSS;
        if (v_edge && state != SEARCH) v_nxt = VSS;
    end

    always_comb begin
        lock_nxt = (state_nxt == LOCKED);
        act_nxt  = lock_nxt && (h_nxt < HV) && (v_nxt < VV);
        fs_nxt   = lock_nxt && (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive end of the VGA timing interface: consumes raw hsync/vsync and reconstructs haddr/vaddr pixel coordinates, aligned to the 640x480@60 generator.
- Checks every sync edge against the expected position, reports lock and counts timing errors.
- Used on-chip as a timing self-checker for the game's VGA path, and as the coordinate source for any block fed only by sync lines.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch (H_TOTAL = 800)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch (V_TOTAL = 525)
- HSYNC_POL, 0, active level of hsync_in (0 = active-low)
- VSYNC_POL, 0, active level of vsync_in

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hsync_in  in  1  horizontal sync, same clock domain
- vsync_in  in  1  vertical sync, same clock domain
- haddr  out  10  recovered column, 0..H_TOTAL-1
- vaddr  out  10  recovered row, 0..V_TOTAL-1
- active  out  1  high when locked, haddr < H_VISIBLE and vaddr < V_VISIBLE
- locked  out  1  high in state LOCKED
- frame_start  out  1  one-cycle pulse when locked and counters become (0,0)
- err_count  out  8  saturating count of timing errors

Behaviour:
- Reset: all outputs 0, state SEARCH, edge registers at inactive level. Reset mid-frame takes effect on the next edge and clears err_count.
- Edge detect:
  - Each sync is registered once.
  - An edge is when the current sample is at its active level and the previous registered sample is inactive.
  - Inputs are not otherwise filtered.
- Counters:
  - haddr increments each cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, vaddr increments and wraps V_TOTAL-1 -> 0.
- Loads:
  - hsync edge: haddr <= H_VISIBLE+H_FRONT (656).
  - vsync edge: vaddr <= V_VISIBLE+V_FRONT (490), applied only outside SEARCH.
  - When both edges occur together, both loads apply.
- Alignment:
  - The generator asserts vsync on the cycle its haddr becomes 0 of row 490.
  - Once locked, haddr/vaddr equal the generator's values delayed by exactly 1 cycle.
- Expected edges:
  - hsync edge expected when internal haddr == 655.
  - vsync edge expected when internal (haddr, vaddr) == (799, 489).
  - A matching edge is a no-op load.
- States:
  - SEARCH: on hsync edge -> H_LOCK.
  - H_LOCK: on first vsync edge -> V_ALIGN (load only).
  - V_ALIGN: vsync edge at expected position -> LOCKED. Mismatched vsync -> reload, stay in V_ALIGN, error.
  - LOCKED: steady state.
- Errors (in H_LOCK, V_ALIGN, LOCKED):
  - hsync edge at haddr != 655, or no hsync edge at haddr == 655 -> SEARCH, error.
  - In LOCKED only: vsync edge off position, or none at (799,489) -> SEARCH, error.
  - Each error increments err_count by 1, saturating at 255.
  - SEARCH never counts errors.
- Output gating:
  - active, locked and frame_start are 0 outside LOCKED.
  - haddr/vaddr keep counting in every state.
- Output timing: all outputs are registered; locked rises the cycle after the qualifying vsync edge is sampled.

Decomposition:
- Package vga_timing_pkg holds:
  - H_/V_ timing constants and derived H_TOTAL, V_TOTAL, H_SYNC_START, V_SYNC_START.
  - The state enum (SEARCH, H_LOCK, V_ALIGN, LOCKED).
  - The package is shared with the existing vga timing generator.
- One sub-module, sync_edge_detect (param POL; register plus edge pulse), instantiated for hsync and vsync.

Test Plan:
- Drive from the existing vga generator, releasing both resets together at cycle 0:
  - locked rises at cycle 812001 (second vsync at generator cycle 812000).
  - Thereafter haddr/vaddr equal the generator's values delayed 1 cycle for 2 full frames.
  - frame_start pulses once every 420000 cycles; err_count stays 0.
- While LOCKED, delay one hsync edge by 1 cycle:
  - locked drops next cycle; err_count = 1.
  - Relock occurs exactly 2 vsync edges later.
- While LOCKED, suppress one vsync pulse:
  - locked drops on the cycle after internal (799,489); err_count increments by 1.
- Hold hsync_in = vsync_in = 1 (inactive) for 1,000,000 cycles:
  - State stays SEARCH; locked = active = 0; err_count = 0.
- Assert rst for 1 cycle mid-frame while LOCKED with err_count = 3:
  - Next cycle all outputs = 0 and err_count = 0.
  - Relock follows normal timing.
- Instantiate with HSYNC_POL = VSYNC_POL = 1 and drive inverted syncs:
  - Lock timing and coordinates are identical to the first scenario.
